// File: rtl/fb_pingpong_ctrl.sv
// Ping-pong frame-buffer controller: two banks in one SDP RAM.
// Frames fill alternating banks and are served to the reader in order.
module fb_pingpong_ctrl #(
  parameter int MEM_DEPTH  = 130560,
  parameter int ADDR_WIDTH = 17,
  parameter int DATA_WIDTH = 16
) (
  input  logic                  iClk,
  input  logic                  iRst,
  input  logic                  i_Clk_en,
  input  logic                  i_wr_valid,
  input  logic [ADDR_WIDTH-1:0] i_wr_addr,
  input  logic [DATA_WIDTH-1:0] i_wr_data,
  output logic                  o_wr_rearm,
  output logic                  o_wmem_we,
  output logic [ADDR_WIDTH:0]   o_wmem_addr,
  output logic [DATA_WIDTH-1:0] o_wmem_data,
  output logic [ADDR_WIDTH:0]   o_rmem_addr,
  input  logic [DATA_WIDTH-1:0] i_rmem_data,
  output logic                  o_rd_frame_avail,
  input  logic                  i_rd_en,
  output logic                  o_rd_valid,
  output logic [DATA_WIDTH-1:0] o_rd_data,
  output logic                  o_rd_last,
  output logic [7:0]            o_drop_cnt
);

  localparam logic [ADDR_WIDTH-1:0] LAST =
    ADDR_WIDTH'(MEM_DEPTH - 1);

  typedef enum logic [1:0] {
    W_IDLE,
    W_FILL,
    W_DROP
  } wstate_t;

  typedef enum logic {
    R_IDLE,
    R_READ
  } rstate_t;

  wstate_t               w_q, w_d;
  rstate_t               r_q, r_d;
  logic [1:0]            full_q, full_d;
  logic                  wr_bank_q, wr_bank_d;
  logic                  rd_bank_q, rd_bank_d;
  logic [ADDR_WIDTH-1:0] rd_cnt_q, rd_cnt_d;
  logic [7:0]            drop_q, drop_d;
  logic                  rearm_q, rearm_d;
  logic                  vld_q, last_q;

  logic wr_px, wr_last, we, fill_done;
  logic avail, issue, rd_end;

  // Reset cycle must not leak a write strobe or read issue.
  assign wr_px   = i_Clk_en & i_wr_valid & ~iRst;
  assign wr_last = wr_px & (i_wr_addr == LAST);

  always_comb begin
    w_d       = w_q;
    we        = 1'b0;
    fill_done = 1'b0;
    rearm_d   = 1'b0;
    drop_d    = drop_q;
    unique case (w_q)
      W_IDLE: begin
        if (wr_px && i_wr_addr == '0) begin
          if (!full_q[wr_bank_q]) begin
            w_d = W_FILL;
            we  = 1'b1;
          end else begin
            w_d = W_DROP;
            if (drop_q != 8'hFF)
              drop_d = drop_q + 8'd1;
          end
        end
      end
      W_FILL: begin
        we = wr_px;
        if (wr_last) begin
          fill_done = 1'b1;
          rearm_d   = 1'b1;
          w_d       = W_IDLE;
        end
      end
      W_DROP: begin
        if (wr_last) begin
          rearm_d = 1'b1;
          w_d     = W_IDLE;
        end
      end
      default: w_d = W_IDLE;
    endcase
  end

  assign avail  = full_q[rd_bank_q] & (r_q == R_IDLE);
  assign issue  = i_rd_en & ~iRst
                & (avail | (r_q == R_READ));
  assign rd_end = issue & (rd_cnt_q == LAST);

  always_comb begin
    r_d       = r_q;
    rd_cnt_d  = rd_cnt_q;
    rd_bank_d = rd_bank_q;
    if (issue) begin
      if (rd_end) begin
        r_d       = R_IDLE;
        rd_cnt_d  = '0;
        rd_bank_d = ~rd_bank_q;
      end else begin
        r_d      = R_READ;
        rd_cnt_d = rd_cnt_q + ADDR_WIDTH'(1);
      end
    end
  end

  // Fill and release always target different banks.
  always_comb begin
    full_d = full_q;
    if (fill_done)
      full_d[wr_bank_q] = 1'b1;
    if (rd_end)
      full_d[rd_bank_q] = 1'b0;
    wr_bank_d = wr_bank_q ^ fill_done;
  end

  always_ff @(posedge iClk) begin
    if (iRst) begin
      w_q       <= W_IDLE;
      r_q       <= R_IDLE;
      full_q    <= 2'b00;
      wr_bank_q <= 1'b0;
      rd_bank_q <= 1'b0;
      rd_cnt_q  <= '0;
      drop_q    <= 8'd0;
      rearm_q   <= 1'b0;
      vld_q     <= 1'b0;
      last_q    <= 1'b0;
    end else begin
      w_q       <= w_d;
      r_q       <= r_d;
      full_q    <= full_d;
      wr_bank_q <= wr_bank_d;
      rd_bank_q <= rd_bank_d;
      rd_cnt_q  <= rd_cnt_d;
      drop_q    <= drop_d;
      rearm_q   <= rearm_d;
      vld_q     <= issue;
      last_q    <= rd_end;
    end
  end

  assign o_wr_rearm       = rearm_q;
  assign o_wmem_we        = we;
  assign o_wmem_addr      = we ? {wr_bank_q, i_wr_addr} : '0;
  assign o_wmem_data      = we ? i_wr_data : '0;
  assign o_rmem_addr      = {rd_bank_q, rd_cnt_q};
  assign o_rd_frame_avail = avail;
  assign o_rd_valid       = vld_q;
  assign o_rd_data        = vld_q ? i_rmem_data : '0;
  assign o_rd_last        = last_q;
  assign o_drop_cnt       = drop_q;

endmodule

// File: tb/tb_fb_pingpong_ctrl.sv
// Bench for fb_pingpong_ctrl: directed vectors plus randomized
// traffic against a frame-queue reference model.
`timescale 1ns/1ps
module tb_fb_pingpong_ctrl;

  localparam int MD = 8;
  localparam int AW = 3;
  localparam int DW = 16;

  logic          clk = 0;
  logic          rst = 1;
  logic          en = 0;
  logic          v = 0;
  logic [AW-1:0] a = '0;
  logic [DW-1:0] d = '0;
  logic          rearm, we;
  logic [AW:0]   waddr, raddr;
  logic [DW-1:0] wdata, rdata, rdat;
  logic          avail, rvld, rlast;
  logic          rd_en = 0;
  logic [7:0]    drop;

  fb_pingpong_ctrl #(
    .MEM_DEPTH (MD),
    .ADDR_WIDTH(AW),
    .DATA_WIDTH(DW)
  ) dut (
    .iClk            (clk),
    .iRst            (rst),
    .i_Clk_en        (en),
    .i_wr_valid      (v),
    .i_wr_addr       (a),
    .i_wr_data       (d),
    .o_wr_rearm      (rearm),
    .o_wmem_we       (we),
    .o_wmem_addr     (waddr),
    .o_wmem_data     (wdata),
    .o_rmem_addr     (raddr),
    .i_rmem_data     (rdata),
    .o_rd_frame_avail(avail),
    .i_rd_en         (rd_en),
    .o_rd_valid      (rvld),
    .o_rd_data       (rdat),
    .o_rd_last       (rlast),
    .o_drop_cnt      (drop)
  );

  always #10 clk = ~clk;

  logic [DW-1:0] mem [2*MD];
  always @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    rdata <= mem[raddr];
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t",
               nm, act, exp, $time);
    end
  endtask

  int rd_mode = 0;
  always @(posedge clk) begin
    #1;
    case (rd_mode)
      0: rd_en = 0;
      1: rd_en = 1;
      2: rd_en = ~rd_en;
      default: rd_en = 1'($urandom_range(0, 1));
    endcase
  end

  // Reference model: frames held as a pixel queue plus frame count.
  bit            chk_en = 0;
  int            nfr, m_ridx, m_drop, m_w, sz;
  bit            m_wb, m_rb, m_rd, keep, iss;
  logic          p_rearm, p_valid, p_last;
  logic [DW-1:0] p_data;
  logic [DW-1:0] pq [$];
  logic [DW-1:0] cur [MD];
  int            n_rearm = 0;
  int            n_valid = 0;

  always @(negedge clk) begin
    if (chk_en) begin
      chk("rearm", rearm, p_rearm);
      chk("rd_valid", rvld, p_valid);
      chk("rd_last", rlast, p_last);
      if (p_valid) chk("rd_data", rdat, p_data);
      chk("drop_cnt", drop, m_drop);
      if (rearm) n_rearm++;
      if (rvld) n_valid++;
      sz = nfr;
      if (rst) begin
        pq.delete();
        nfr = 0; m_ridx = 0; m_drop = 0; m_w = 0;
        m_wb = 0; m_rb = 0; m_rd = 0;
        p_rearm = 0; p_valid = 0; p_last = 0; p_data = 0;
      end else begin
        keep = en && v && (m_w == 1 ||
               (m_w == 0 && a == 0 && sz < 2));
        iss  = rd_en && (m_rd || sz > 0);
        chk("avail", avail, !m_rd && sz > 0);
        chk("we", we, keep);
        if (keep) begin
          chk("waddr", waddr, {m_wb, a});
          chk("wdata", wdata, d);
        end
        if (iss) chk("raddr", raddr, {m_rb, 3'(m_ridx)});
        p_rearm = en && v && a == AW'(MD - 1) && m_w != 0;
        p_valid = iss;
        p_last  = 0;
        if (iss) begin
          p_data = pq.pop_front();
          p_last = (m_ridx == MD - 1);
          m_ridx++;
          m_rd = 1;
          if (m_ridx == MD) begin
            nfr--; m_rb = ~m_rb; m_rd = 0; m_ridx = 0;
          end
        end
        if (en && v) begin
          if (m_w == 0 && a == 0) begin
            if (sz < 2) begin
              m_w = 1; cur[0] = d;
            end else begin
              m_w = 2;
              if (m_drop < 255) m_drop++;
            end
          end else if (m_w == 1) begin
            cur[a] = d;
            if (a == AW'(MD - 1)) begin
              for (int i = 0; i < MD; i++) pq.push_back(cur[i]);
              nfr++; m_wb = ~m_wb; m_w = 0;
            end
          end else if (m_w == 2 && a == AW'(MD - 1)) begin
            m_w = 0;
          end
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic at_neg();
    @(negedge clk);
    #1;
  endtask

  task automatic do_reset();
    tick(1);
    rst = 1; v = 0; en = 0;
    tick(2);
    rst = 0;
  endtask

  task automatic check_zero(input string tag);
    chk({tag, ".we"}, we, 0);
    chk({tag, ".waddr"}, waddr, 0);
    chk({tag, ".wdata"}, wdata, 0);
    chk({tag, ".raddr"}, raddr, 0);
    chk({tag, ".avail"}, avail, 0);
    chk({tag, ".rvld"}, rvld, 0);
    chk({tag, ".rdat"}, rdat, 0);
    chk({tag, ".rlast"}, rlast, 0);
    chk({tag, ".drop"}, drop, 0);
    chk({tag, ".rearm"}, rearm, 0);
  endtask

  task automatic send_frame(input logic [DW-1:0] base,
                            input int en_mode,
                            input int npix);
    bit done;
    for (int i = 0; i < npix; i++) begin
      done = 0;
      while (!done) begin
        tick(1);
        v = 1; a = AW'(i); d = base + DW'(i);
        case (en_mode)
          0: en = 1;
          1: en = ~en;
          default: en = ($urandom_range(0, 3) != 0);
        endcase
        done = en;
      end
    end
    if (npix == MD) begin
      tick(1);
      v = 0; a = AW'($urandom_range(0, MD - 1));
    end
  endtask

  typedef struct {
    logic          v;
    logic          en;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    logic          we;
    logic [AW:0]   wa;
    logic [DW-1:0] wd;
  } vec_t;

  vec_t tv [6];
  int   r0, v0;

  initial begin
    #1000000;
    $display("FAIL watchdog: timeout reached");
    $fatal(1, "watchdog");
  end

  initial begin
    tv[0] = '{1, 1, 3'd0, 16'h1234, 1, 4'h0, 16'h1234};
    tv[1] = '{1, 1, 3'd3, 16'h5555, 0, 4'h0, 16'h0000};
    tv[2] = '{1, 0, 3'd0, 16'h7777, 0, 4'h0, 16'h0000};
    tv[3] = '{0, 1, 3'd0, 16'h8888, 0, 4'h0, 16'h0000};
    tv[4] = '{1, 1, 3'd7, 16'h9999, 0, 4'h0, 16'h0000};
    tv[5] = '{1, 1, 3'd0, 16'hABCD, 1, 4'h0, 16'hABCD};

    rst = 1;
    repeat (2) @(posedge clk);
    chk_en = 1;
    at_neg();
    check_zero("reset");
    tick(1);
    rst = 0;

    for (int i = 0; i < 6; i++) begin
      v = tv[i].v; en = tv[i].en; a = tv[i].a; d = tv[i].d;
      #1;
      chk($sformatf("vec%0d.we", i), we, tv[i].we);
      chk($sformatf("vec%0d.waddr", i), waddr, tv[i].wa);
      chk($sformatf("vec%0d.wdata", i), wdata, tv[i].wd);
    end
    v = 0; en = 0;

    r0 = n_rearm;
    send_frame(16'h0100, 0, MD);
    tick(3);
    at_neg();
    chk("A.avail", avail, 1);
    chk("A.rearm_cnt", n_rearm - r0, 1);
    v0 = n_valid;
    rd_mode = 1;
    tick(12);
    rd_mode = 0;
    at_neg();
    chk("A.valid_cnt", n_valid - v0, MD);
    chk("A.avail_after", avail, 0);

    do_reset();
    r0 = n_rearm;
    send_frame(16'h0A00, 0, MD);
    send_frame(16'h0B00, 0, MD);
    send_frame(16'h0C00, 0, MD);
    tick(2);
    at_neg();
    chk("ABC.drop", drop, 1);
    chk("ABC.rearm_cnt", n_rearm - r0, 3);
    v0 = n_valid;
    rd_mode = 2;
    tick(44);
    rd_mode = 0;
    tick(2);
    at_neg();
    chk("toggle.valid_cnt", n_valid - v0, 2 * MD);
    chk("toggle.avail", avail, 0);

    v0 = n_valid;
    send_frame(16'h0E00, 1, MD);
    en = 1;
    rd_mode = 1;
    tick(12);
    rd_mode = 0;
    at_neg();
    chk("clken.valid_cnt", n_valid - v0, MD);

    send_frame(16'h0F00, 0, 5);
    rst = 1;
    tick(1);
    rst = 0; a = 3'd5;
    at_neg();
    check_zero("rst_fill");
    v = 0;
    send_frame(16'h0D00, 0, MD);
    rd_mode = 1;
    tick(4);
    rst = 1;
    tick(1);
    rst = 0;
    at_neg();
    check_zero("rst_read");
    rd_mode = 0;
    send_frame(16'h0200, 0, MD);
    tick(1);
    at_neg();
    chk("restart.drop", drop, 0);
    chk("restart.avail", avail, 1);

    do_reset();
    rd_mode = 3;
    for (int f = 0; f < 25; f++) begin
      send_frame(DW'($urandom_range(0, 16'hFFF0)), 2, MD);
      en = 1;
      tick($urandom_range(0, 6));
    end
    rd_mode = 1;
    tick(40);
    rd_mode = 0;
    at_neg();
    chk("rand.avail", avail, 0);

    do_reset();
    for (int f = 0; f < 260; f++)
      send_frame(DW'(f * 16), 0, MD);
    tick(2);
    at_neg();
    chk("sat.drop", drop, 255);

    chk_en = 0;
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/fb_pingpong_ctrl.md
Name: fb_pingpong_ctrl

Overview:
- Ping-pong frame-buffer controller between the RGB888→RGB565 pixel writer and the CNN input reader.
- Owns two MEM_DEPTH-pixel banks in one simple-dual-port RAM (bank = address MSB).
- Steers each incoming frame into a free bank, or drops it. Re-arms the pixel writer after each frame.
- Serves completed frames to the reader in arrival order, with 1-cycle RAM read latency.

Parameters:
- MEM_DEPTH, 130560, pixels per frame/bank.
- ADDR_WIDTH, 17, per-bank pixel address width (ceil(log2(MEM_DEPTH))).
- DATA_WIDTH, 16, RGB565 pixel width.

Ports:
- iClk  in  1  single clock.
- iRst  in  1  synchronous, active-high reset.
- i_Clk_en  in  1  write-side enable; gates write FSM and write strobe.
- i_wr_valid  in  1  pixel valid from writer.
- i_wr_addr  in  ADDR_WIDTH  pixel index from writer.
- i_wr_data  in  DATA_WIDTH  RGB565 pixel.
- o_wr_rearm  out  1  1-cycle pulse: restart the pixel writer for the next frame.
- o_wmem_we  out  1  RAM write enable.
- o_wmem_addr  out  ADDR_WIDTH+1  {bank, pixel addr}.
- o_wmem_data  out  DATA_WIDTH  RAM write data.
- o_rmem_addr  out  ADDR_WIDTH+1  {bank, pixel addr}; RAM registers read on the same edge.
- i_rmem_data  in  DATA_WIDTH  RAM read data, valid 1 cycle after address.
- o_rd_frame_avail  out  1  a full bank is ready for the reader.
- i_rd_en  in  1  reader pulls one pixel this cycle.
- o_rd_valid  out  1  o_rd_data valid.
- o_rd_data  out  DATA_WIDTH  pixel to the CNN.
- o_rd_last  out  1  with o_rd_valid on pixel MEM_DEPTH-1.
- o_drop_cnt  out  8  dropped-frame count, saturates at 255.

Behaviour:
- Reset (iRst on a clock edge):
  - Every output = 0.
  - full[1:0]=0, wr_bank=0, rd_bank=0, rd_cnt=0.
  - Write FSM = W_IDLE, read FSM = R_IDLE.
  - Reset mid-frame discards all bank contents and state; no pulses follow.
- Write FSM (advances only when i_Clk_en=1):
  - W_IDLE: a frame start is i_wr_valid=1 with i_wr_addr=0.
    - If full[wr_bank]=0 (registered value): go to W_FILL and write this pixel.
    - Else: go to W_DROP, and o_drop_cnt +1 (saturating).
    - Any valid with i_wr_addr≠0 in W_IDLE is ignored.
  - W_FILL: o_wmem_we = i_wr_valid & i_Clk_en. o_wmem_addr = {wr_bank, i_wr_addr}. o_wmem_data = i_wr_data. All are combinational pass-through, 0 added latency.
    - Valid with i_wr_addr=MEM_DEPTH-1 (written): full[wr_bank] set next edge, wr_bank toggles, o_wr_rearm pulses next cycle, return to W_IDLE.
  - W_DROP: o_wmem_we=0. Valid with i_wr_addr=MEM_DEPTH-1: o_wr_rearm pulses next cycle, return to W_IDLE; wr_bank unchanged.
  - i_Clk_en=0: state holds, o_wmem_we=0, pixels ignored.
- Read FSM (every cycle, independent of i_Clk_en):
  - o_rd_frame_avail = full[rd_bank] & (read FSM in R_IDLE).
  - R_IDLE: i_rd_en=1 while avail: go to R_READ, issue rd_cnt=0 this cycle.
  - R_READ: each cycle with i_rd_en=1, o_rmem_addr = {rd_bank, rd_cnt} and rd_cnt+1. i_rd_en=0 stalls; the address holds and no valid is produced.
  - Last address (rd_cnt=MEM_DEPTH-1) issued: full[rd_bank] cleared next edge, rd_bank toggles, rd_cnt=0, return to R_IDLE.
  - i_rd_en in R_IDLE with avail=0 is ignored.
  - o_rd_valid is the registered "address issued" flag, 1 cycle later. o_rd_data = i_rmem_data. o_rd_last is registered alongside.
- Simultaneous events:
  - Fill-complete on one bank and read-release on the other in the same cycle: both take effect.
  - Frame start in the same cycle the reader releases wr_bank: the write side sees old full=1, so the frame is dropped.
  - A bank being read stays full until released, so it is never overwritten.
- Ordering: banks are filled and read strictly alternately (0,1,0,…). The reader never sees a frame out of order.

Test Plan (MEM_DEPTH=8, ADDR_WIDTH=3 in sim):
- Reset, then frame A (pixels 0x0100+i, addr 0..7), i_Clk_en=1 → we on bank0 addr 0..7; full=01; o_wr_rearm pulses once, 1 cycle after addr 7; o_rd_frame_avail=1.
- Hold i_rd_en=1 after frame A → o_rmem_addr 0..7 (bank0); o_rd_valid 8 cycles, 1 cycle behind addr; data 0x0100..0x0107; o_rd_last on 0x0107; avail=0; full=00.
- Write frames A, B, C with no reads → A→bank0, B→bank1, C dropped (we=0 for all 8 pixels); o_drop_cnt=1; rearm pulses 3 times.
- Read with i_rd_en toggling 1,0,1,0… → 8 valids over ~16 cycles; no duplicated or skipped pixel.
- i_Clk_en toggled during frame fill → writes only on enabled cycles; full set only after an enabled addr 7.
- iRst asserted mid-fill (addr 4) and mid-read → all outputs 0 next cycle; frame restart at addr 0 lands in bank0; o_drop_cnt=0.
